// File: rtl/tt_um_logarithmic_afpm_pkg.sv
// tt_um_logarithmic_afpm_pkg: shared FP16 field layout, bias and special encodings for the Mitchell multiplier
package tt_um_logarithmic_afpm_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS = 15;
  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] INF = 16'h7C00;
  localparam logic [15:0] MAXF = 16'h7BFF;
  localparam logic [15:0] ZERO = 16'h0000;
  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;
endpackage

// File: rtl/tt_um_logarithmic_afpm_core.sv
// afpm_mitchell_core: combinational FP16 multiply by Mitchell log approximation (a, b -> p); AFPM_SPECIAL_EN adds inf/NaN handling
module afpm_mitchell_core
  import tt_um_logarithmic_afpm_pkg::*;
#(
  parameter int BIAS = tt_um_logarithmic_afpm_pkg::BIAS
) (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);
  fp16_t fa, fb;
  logic sign, za, zb, uf, of;
  logic [FRAC_W:0] s;
  logic signed [6:0] e;
  logic [15:0] norm;
  assign fa = fp16_t'(a);
  assign fb = fp16_t'(b);
  assign sign = fa.sign ^ fb.sign;
  assign za = fa.exp == '0;
  assign zb = fb.exp == '0;
  // Adding the fractions is the log-domain multiply; the carry renormalises
  assign s = {1'b0, fa.frac} + {1'b0, fb.frac};
  assign e = 7'(fa.exp) + 7'(fb.exp) - 7'(BIAS) + 7'(s[FRAC_W]);
  assign uf = e <= 7'sd0;
  assign of = e >= 7'sd31;
  assign norm = {sign, e[EXP_W-1:0], s[FRAC_W-1:0]};
`ifdef AFPM_SPECIAL_EN
  logic inf_a, inf_b, nan;
  assign inf_a = (&fa.exp) && fa.frac == '0;
  assign inf_b = (&fb.exp) && fb.frac == '0;
  assign nan = ((&fa.exp) && fa.frac != '0) || ((&fb.exp) && fb.frac != '0) || (inf_a && zb) || (inf_b && za);
  always_comb
    p = nan ? QNAN :
        (inf_a || inf_b) ? {sign, INF[14:0]} :
        (za || zb || uf) ? {sign, ZERO[14:0]} :
        of ? {sign, INF[14:0]} : norm;
`else
  always_comb
    p = (za || zb || uf) ? {sign, ZERO[14:0]} :
        of ? {sign, MAXF[14:0]} : norm;
`endif
endmodule

// File: rtl/tt_um_logarithmic_afpm.sv
// tt_um_logarithmic_afpm: 4-phase byte-serial framing around the Mitchell FP16 multiplier.
// Ports: clk, rst (sync, active-high), ena (hold when low), ui_in/uio_in operand bytes (low then high),
// uo_out product bytes (low after phase 2, high after phase 3), uio_out/uio_oe tied low.
// Optional macro AFPM_SPECIAL_EN enables infinity/NaN handling in the core.
module tt_um_logarithmic_afpm
  import tt_um_logarithmic_afpm_pkg::*;
#(
  parameter int BIAS = tt_um_logarithmic_afpm_pkg::BIAS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [1:0] ph;
  logic [15:0] a, b, p, p_c;
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
  afpm_mitchell_core #(.BIAS(BIAS)) u_core (.a(a), .b(b), .p(p_c));
  always_ff @(posedge clk)
    if (rst) begin
      ph <= 2'd0;
      a <= '0;
      b <= '0;
      p <= '0;
      uo_out <= 8'h00;
    end else if (ena) begin
      ph <= ph + 2'd1;
      if (ph == 2'd0) begin
        a[7:0] <= ui_in;
        b[7:0] <= uio_in;
      end
      if (ph == 2'd1) begin
        a[15:8] <= ui_in;
        b[15:8] <= uio_in;
      end
      if (ph == 2'd2) begin
        p <= p_c;
        uo_out <= p_c[7:0];
      end
      if (ph == 2'd3) uo_out <= p[15:8];
    end
endmodule

// File: tb/tb_tt_um_logarithmic_afpm.sv
// tb_tt_um_logarithmic_afpm: directed scoreboard bench for the byte-serial Mitchell FP16 multiplier
module tb_tt_um_logarithmic_afpm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  logic [7:0] last_hi = 8'h00;

  tt_um_logarithmic_afpm dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s got=%h exp=<empty scoreboard>", tag, uo_out);
    end else begin
      e = sb.pop_front();
      chk(tag, uo_out, e);
    end
  endtask

  // One frame from phase 0; stall=1 drops ena for 3 cycles after the low-byte capture
  task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e, input bit stall);
    sb.push_back(e[7:0]);
    sb.push_back(e[15:8]);
    for (int c = 0; c < 4; c++) begin
      ena = 1'b1;
      ui_in = c == 0 ? a[7:0] : a[15:8];
      uio_in = c == 0 ? b[7:0] : b[15:8];
      @(posedge clk);
      #1;
      if (c == 2) pop_chk($sformatf("%h*%h lo", a, b));
      if (c == 3) pop_chk($sformatf("%h*%h hi", a, b));
      if (c == 0 && stall) begin
        ena = 1'b0;
        ui_in = 8'hA5;
        uio_in = 8'h5A;
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("stall_hold", uo_out, last_hi);
        end
      end
    end
    last_hi = e[15:8];
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_uo_out", uo_out, 8'h00);
    chk("uio_out_tie", uio_out, 8'h00);
    chk("uio_oe_tie", uio_oe, 8'h00);
    rst = 1'b0;
    frame(16'h3E00, 16'h4200, 16'h4400, 1'b0);
    frame(16'h3C00, 16'h3C00, 16'h3C00, 1'b0);
    frame(16'h3E00, 16'h3E00, 16'h4000, 1'b0);
    frame(16'hBC00, 16'h4000, 16'hC000, 1'b0);
    frame(16'h0000, 16'h4200, 16'h0000, 1'b0);
    frame(16'h8000, 16'h3C00, 16'h8000, 1'b0);
    frame(16'h0400, 16'h0400, 16'h0000, 1'b0);
    frame(16'h3E00, 16'h3D00, 16'h3F00, 1'b0);
    frame(16'hC200, 16'hC200, 16'h4800, 1'b0);
    frame(16'h0400, 16'h3800, 16'h0000, 1'b0);
    frame(16'h0400, 16'h3C00, 16'h0400, 1'b0);
    frame(16'h7800, 16'h3C00, 16'h7800, 1'b0);
`ifdef AFPM_SPECIAL_EN
    frame(16'h7BFF, 16'h7BFF, 16'h7C00, 1'b0);
    frame(16'h7800, 16'h4000, 16'h7C00, 1'b0);
    frame(16'h7C00, 16'h0000, 16'h7E00, 1'b0);
    frame(16'h7C00, 16'h3C00, 16'h7C00, 1'b0);
    frame(16'h7E00, 16'h3C00, 16'h7E00, 1'b0);
    frame(16'hFC00, 16'h4000, 16'hFC00, 1'b0);
`else
    frame(16'h7BFF, 16'h7BFF, 16'h7BFF, 1'b0);
    frame(16'h7800, 16'h4000, 16'h7BFF, 1'b0);
    frame(16'h7C00, 16'h0000, 16'h0000, 1'b0);
    frame(16'h7C00, 16'h3C00, 16'h7BFF, 1'b0);
    frame(16'h7E00, 16'h3C00, 16'h7BFF, 1'b0);
    frame(16'hFC00, 16'h4000, 16'hFBFF, 1'b0);
`endif
    frame(16'h3E00, 16'h4200, 16'h4400, 1'b1);
    ena = 1'b1;
    ui_in = 8'h00;
    uio_in = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ui_in = 8'h3C;
    uio_in = 8'h3C;
    @(posedge clk);
    #1;
    chk("midframe_reset_uo_out", uo_out, 8'h00);
    rst = 1'b0;
    last_hi = 8'h00;
    frame(16'h3E00, 16'h3E00, 16'h4000, 1'b0);
    frame(16'hBC00, 16'h4000, 16'hC000, 1'b1);
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
